// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: start/stop/clear/lap FSM, BCD mm:ss.cc counter and divider control.
// Optional lap hold (LAP state + lap capture register) enabled by defining STOPWATCH_LAP_HOLD_EN.
module stopwatch_ctrl #(
    parameter int nBit       = 32'd18,
    parameter int LIMIT_NORM = 32'd124999,
    parameter int LIMIT_FAST = 32'd12499
) (
    input  logic            clk_base,
    input  logic            reset,
    input  logic            btn_ss,
    input  logic            btn_clr,
    input  logic            btn_lap,
    input  logic            fast,
    input  logic            tick_in,
    output logic            run_en,
    output logic            div_reset,
    output logic [nBit-1:0] limit,
    output logic [1:0]      state,
    output logic [7:0]      disp_min,
    output logic [7:0]      disp_sec,
    output logic [7:0]      disp_cs,
    output logic            overflow
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_LAP   = 2'b11
    } state_t;

    localparam logic [nBit-1:0] LIM_NORM_C = nBit'(LIMIT_NORM);
    localparam logic [nBit-1:0] LIM_FAST_C = nBit'(LIMIT_FAST);

    // Count layout is {min_hi, min_lo, sec_hi, sec_lo, cs_hi, cs_lo}; returns {wrap, next}.
    function automatic logic [24:0] bcd_inc(input logic [23:0] cnt);
        logic [23:0] res;
        logic        carry;
        logic [3:0]  top;
        res   = cnt;
        carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            top = ((i == 3) || (i == 5)) ? 4'd5 : 4'd9;
            if (carry) begin
                if (res[i*4 +: 4] == top) begin
                    res[i*4 +: 4] = 4'd0;
                end else begin
                    res[i*4 +: 4] = res[i*4 +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end else begin
                res[i*4 +: 4] = res[i*4 +: 4];
            end
        end
        return {carry, res};
    endfunction

    state_t            state_r, state_s;
    logic              ss_q_r, clr_q_r, lap_q_r, tick_q_r;
    logic              ss_p_s, clr_p_s, lap_p_s, tick_p_s;
    logic [23:0]       count_r, count_s, inc_s, disp_r, disp_s;
    logic              wrap_s;
    logic              overflow_r, overflow_s;
    logic              run_en_r, run_en_s;
    logic              div_reset_r, div_reset_s;
    logic [nBit-1:0]   limit_r, limit_s;
    logic              running_s;

    assign ss_p_s    = btn_ss  & ~ss_q_r;
    assign clr_p_s   = btn_clr & ~clr_q_r;
    assign lap_p_s   = btn_lap & ~lap_q_r;
    assign tick_p_s  = tick_in & ~tick_q_r;
    assign running_s = (state_r == ST_RUN) || (state_r == ST_LAP);
    assign {wrap_s, inc_s} = bcd_inc(count_r);

`ifdef STOPWATCH_LAP_HOLD_EN
    logic [23:0] lap_r, lap_s;

    // Lap capture register, frozen while the display is held.
    always_ff @(posedge clk_base) begin
        if (reset) begin
            lap_r <= 24'h000000;
        end else begin
            lap_r <= lap_s;
        end
    end
`endif

    // Next-state, counter, divider-control and display computation.
    always_comb begin
        state_s     = state_r;
        count_s     = count_r;
        overflow_s  = overflow_r;
        div_reset_s = 1'b0;
`ifdef STOPWATCH_LAP_HOLD_EN
        lap_s       = lap_r;
`endif
        if (state_r == ST_IDLE) begin
            limit_s = fast ? LIM_FAST_C : LIM_NORM_C;
        end else begin
            limit_s = limit_r;
        end

        if (clr_p_s && ((state_r == ST_IDLE) || (state_r == ST_PAUSE))) begin
            state_s     = ST_IDLE;
            count_s     = 24'h000000;
            overflow_s  = 1'b0;
            div_reset_s = 1'b1;
        end else if (ss_p_s) begin
            case (state_r)
                ST_IDLE:  state_s = ST_RUN;
                ST_PAUSE: state_s = ST_RUN;
                ST_RUN:   state_s = ST_PAUSE;
                ST_LAP:   state_s = ST_PAUSE;
                default:  state_s = ST_IDLE;
            endcase
`ifdef STOPWATCH_LAP_HOLD_EN
        end else if (lap_p_s && running_s) begin
            if (state_r == ST_RUN) begin
                state_s = ST_LAP;
                lap_s   = count_r;
            end else begin
                state_s = ST_RUN;
            end
`endif
        end else if (tick_p_s && running_s) begin
            count_s    = inc_s;
            overflow_s = overflow_r | wrap_s;
        end else begin
            count_s = count_r;
        end

        run_en_s = (state_s == ST_RUN) || (state_s == ST_LAP);
`ifdef STOPWATCH_LAP_HOLD_EN
        disp_s = (state_s == ST_LAP) ? lap_s : count_s;
`else
        disp_s = count_s;
`endif
    end

`ifndef STOPWATCH_LAP_HOLD_EN
    logic unused_lap_s;
    assign unused_lap_s = lap_p_s;
`endif

    // State, edge-detect copies and all output registers.
    always_ff @(posedge clk_base) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            ss_q_r      <= 1'b0;
            clr_q_r     <= 1'b0;
            lap_q_r     <= 1'b0;
            tick_q_r    <= 1'b0;
            count_r     <= 24'h000000;
            disp_r      <= 24'h000000;
            overflow_r  <= 1'b0;
            run_en_r    <= 1'b0;
            div_reset_r <= 1'b0;
            limit_r     <= LIM_NORM_C;
        end else begin
            state_r     <= state_s;
            ss_q_r      <= btn_ss;
            clr_q_r     <= btn_clr;
            lap_q_r     <= btn_lap;
            tick_q_r    <= tick_in;
            count_r     <= count_s;
            disp_r      <= disp_s;
            overflow_r  <= overflow_s;
            run_en_r    <= run_en_s;
            div_reset_r <= div_reset_s;
            limit_r     <= limit_s;
        end
    end

    assign state     = state_r;
    assign run_en    = run_en_r;
    assign div_reset = div_reset_r;
    assign limit     = limit_r;
    assign overflow  = overflow_r;
    assign disp_min  = disp_r[23:16];
    assign disp_sec  = disp_r[15:8];
    assign disp_cs   = disp_r[7:0];

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: vector table, randomized run against a
// centisecond-integer reference model, and directed multi-cycle sequences.
module tb_stopwatch_ctrl;

`ifdef STOPWATCH_LAP_HOLD_EN
    localparam bit LAPEN = 1'b1;
`else
    localparam bit LAPEN = 1'b0;
`endif
    localparam logic [17:0] NORM = 18'd124999;
    localparam logic [17:0] FST  = 18'd12499;

    logic        clk_base = 1'b0;
    logic        reset = 1'b1;
    logic        btn_ss = 1'b0, btn_clr = 1'b0, btn_lap = 1'b0, fast = 1'b0, tick_in = 1'b0;
    logic        run_en, div_reset, overflow;
    logic [17:0] limit;
    logic [1:0]  state;
    logic [7:0]  disp_min, disp_sec, disp_cs;

    int checks = 0;
    int failures = 0;

    stopwatch_ctrl dut (
        .clk_base (clk_base), .reset (reset), .btn_ss (btn_ss), .btn_clr (btn_clr),
        .btn_lap (btn_lap), .fast (fast), .tick_in (tick_in), .run_en (run_en),
        .div_reset (div_reset), .limit (limit), .state (state), .disp_min (disp_min),
        .disp_sec (disp_sec), .disp_cs (disp_cs), .overflow (overflow)
    );

    always #5 clk_base = ~clk_base;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: elapsed time kept as an integer number of centiseconds.
    int          m_mode, m_total, m_lap;
    bit          m_ovf, m_div;
    logic [17:0] m_lim;
    bit          p_ss, p_clr, p_lap, p_tick;

    function automatic logic [23:0] to_bcd(input int t);
        int cs, s, m;
        cs = t % 100;
        s  = (t / 100) % 60;
        m  = t / 6000;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_total = 0; m_lap = 0; m_ovf = 1'b0; m_div = 1'b0; m_lim = NORM;
        p_ss = 1'b0; p_clr = 1'b0; p_lap = 1'b0; p_tick = 1'b0;
    endtask

    task automatic model_step();
        bit ssp, clrp, lapp, tkp, active;
        if (reset) begin
            model_reset();
        end else begin
            ssp = btn_ss & !p_ss; clrp = btn_clr & !p_clr; lapp = btn_lap & !p_lap; tkp = tick_in & !p_tick;
            p_ss = btn_ss; p_clr = btn_clr; p_lap = btn_lap; p_tick = tick_in;
            active = (m_mode == 1) || (m_mode == 3);
            m_div = 1'b0;
            if (m_mode == 0) m_lim = fast ? FST : NORM;
            if (clrp && (m_mode == 0 || m_mode == 2)) begin
                m_mode = 0; m_total = 0; m_ovf = 1'b0; m_div = 1'b1;
            end else if (ssp) begin
                m_mode = active ? 2 : 1;
            end else if (lapp && LAPEN && active) begin
                if (m_mode == 1) begin m_lap = m_total; m_mode = 3; end
                else m_mode = 1;
            end else if (tkp && active) begin
                m_total = (m_total + 1) % 360000;
                if (m_total == 0) m_ovf = 1'b1;
            end
        end
    endtask

    typedef struct {
        logic ss, clr, lap, fast, tick;
        logic [1:0] st;
        logic run, div, lf;
        logic [7:0] cs;
    } vec_t;

    vec_t vecs[22];

    task automatic do_reset();
        reset = 1'b1; btn_ss = 1'b0; btn_clr = 1'b0; btn_lap = 1'b0; fast = 1'b0; tick_in = 1'b0;
        @(negedge clk_base); @(negedge clk_base);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic tick_once();
        tick_in = 1'b1; @(negedge clk_base);
        tick_in = 1'b0; @(negedge clk_base);
    endtask

    task automatic press_ss();
        btn_ss = 1'b1; @(negedge clk_base);
        btn_ss = 1'b0; @(negedge clk_base);
    endtask

    task automatic press_lap();
        btn_lap = 1'b1; @(negedge clk_base);
        btn_lap = 1'b0; @(negedge clk_base);
    endtask

    initial begin
        //            ss    clr   lap   fast  tick  st     run   div   lf    cs
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 8'h00};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 8'h00};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 8'h00};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 8'h01};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 8'h01};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 8'h01};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 8'h00};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 8'h01};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 8'h01};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 8'h01};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 8'h01};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 8'h02};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 8'h02};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 8'h02};
        vecs[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 8'h02};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 8'h02};
        vecs[21] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 8'h02};

        // Reset state
        do_reset();
        check("reset_ctl", {state, run_en, div_reset, overflow, limit}, {2'b00, 1'b0, 1'b0, 1'b0, NORM});
        check("reset_disp", {disp_min, disp_sec, disp_cs}, 24'h000000);

        // Vector table
        for (int i = 0; i < 22; i++) begin
            btn_ss = vecs[i].ss; btn_clr = vecs[i].clr; btn_lap = vecs[i].lap;
            fast = vecs[i].fast; tick_in = vecs[i].tick;
            @(negedge clk_base);
            check($sformatf("vec%0d", i), {state, run_en, div_reset, limit, disp_cs},
                  {vecs[i].st, vecs[i].run, vecs[i].div, (vecs[i].lf ? FST : NORM), vecs[i].cs});
        end

        // Randomized stimulus against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 7) == 0)  btn_ss  = ~btn_ss;
            if ($urandom_range(0, 11) == 0) btn_clr = ~btn_clr;
            if ($urandom_range(0, 5) == 0)  btn_lap = ~btn_lap;
            if ($urandom_range(0, 15) == 0) fast    = ~fast;
            tick_in = 1'($urandom_range(0, 1));
            @(posedge clk_base);
            model_step();
            @(negedge clk_base);
            check("rnd_ctl", {state, run_en, div_reset, overflow, limit},
                  {2'(m_mode), ((m_mode == 1) || (m_mode == 3)), m_div, m_ovf, m_lim});
            check("rnd_disp", {disp_min, disp_sec, disp_cs}, to_bcd((m_mode == 3) ? m_lap : m_total));
        end

        // Start and 250 ticks
        do_reset();
        press_ss();
        for (int i = 0; i < 250; i++) tick_once();
        check("run250_ctl", {state, run_en}, {2'b01, 1'b1});
        check("run250_disp", {disp_min, disp_sec, disp_cs}, 24'h000250);

        // Pause ignores ticks, resume counts again
        press_ss();
        for (int i = 0; i < 5; i++) tick_once();
        check("pause_ctl", {state, run_en}, {2'b10, 1'b0});
        check("pause_disp", {disp_min, disp_sec, disp_cs}, 24'h000250);
        press_ss();
        for (int i = 0; i < 3; i++) tick_once();
        check("resume_disp", {disp_min, disp_sec, disp_cs}, 24'h000253);

        // Clear ignored in RUN, accepted in PAUSE
        btn_clr = 1'b1; @(negedge clk_base);
        check("clr_run", {state, div_reset, disp_min, disp_sec, disp_cs}, {2'b01, 1'b0, 24'h000253});
        btn_clr = 1'b0; @(negedge clk_base);
        press_ss();
        btn_clr = 1'b1; @(negedge clk_base);
        check("clr_pause", {state, run_en, div_reset, disp_min, disp_sec, disp_cs}, {2'b00, 1'b0, 1'b1, 24'h000000});
        btn_clr = 1'b0; @(negedge clk_base);
        check("clr_pulse_end", {1'b0, div_reset}, 2'b00);

        // Wrap from 59:59.99 with sticky overflow
        do_reset();
        press_ss();
        force dut.count_r = 24'h595999;
        @(negedge clk_base);
        release dut.count_r;
        @(negedge clk_base);
        check("preload_disp", {disp_min, disp_sec, disp_cs}, 24'h595999);
        check("preload_ovf", {1'b0, overflow}, 2'b00);
        tick_once();
        check("wrap_disp", {disp_min, disp_sec, disp_cs}, 24'h000000);
        check("wrap_ovf", {state, overflow}, {2'b01, 1'b1});
        tick_once();
        check("wrap_continue", {disp_min, disp_sec, disp_cs}, 24'h000001);
        press_ss();
        check("ovf_pause", {state, overflow}, {2'b10, 1'b1});
        btn_clr = 1'b1; @(negedge clk_base);
        btn_clr = 1'b0; @(negedge clk_base);
        check("ovf_clear", {state, overflow}, {2'b00, 1'b0});

        // Lap hold
        do_reset();
        press_ss();
        for (int i = 0; i < 100; i++) tick_once();
        check("lap_pre", {disp_min, disp_sec, disp_cs}, 24'h000100);
        press_lap();
        for (int i = 0; i < 50; i++) tick_once();
        check("lap_hold_state", {state, run_en}, {(LAPEN ? 2'b11 : 2'b01), 1'b1});
        check("lap_hold_disp", {disp_min, disp_sec, disp_cs}, LAPEN ? 24'h000100 : 24'h000150);
        press_lap();
        check("lap_release_state", {state, run_en}, {2'b01, 1'b1});
        check("lap_release_disp", {disp_min, disp_sec, disp_cs}, 24'h000150);
        tick_once();
        check("lap_after", {disp_min, disp_sec, disp_cs}, 24'h000151);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
